// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit instruction interface between fetch and control.
// Holds the instruction width, the opcode bit encoding and the fetch state enum.
package cpu_pkg;

    localparam int   IW      = 12;
    localparam int   OPC_BIT = 0;
    localparam logic OPC_ADD = 1'b0;
    localparam logic OPC_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: DEPTH x IW register array, one synchronous write port, one async read port.
// Contents are deliberately not reset so a loaded program survives a reset.
module instr_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int IW    = cpu_pkg::IW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: issues a loaded program over a valid/ready handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | program may be loaded; start latches length and issues mem[0]
//   RUN   | instr_valid held; pc advances on each accepted instruction
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int IW    = cpu_pkg::IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    import cpu_pkg::*;

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    fetch_state_t  state;
    logic [AW:0]   last_pc;
    logic [AW:0]   len_clamped;
    logic [AW:0]   len_m1;
    logic          at_last;
    logic          xfer;
    logic          mem_we;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;

    assign len_clamped = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;
    assign len_m1      = len_clamped - (AW+1)'(1);
    assign at_last     = ({1'b0, pc} == last_pc);
    assign xfer        = instr_valid & instr_ready;

    // start wins over a coincident write; reset cycles never write
    assign mem_we = load_we & ~start & ~rst & (state == IDLE);

    // pc+1 is only formed while there is a further instruction to fetch
    assign rd_addr = (state == RUN && !at_last) ? pc + AW'(1) : '0;

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            last_pc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            pc          <= '0;
                            instr       <= rd_data;
                            instr_valid <= 1'b1;
                            last_pc     <= len_m1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (at_last) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            instr_valid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            pc    <= pc + AW'(1);
                            instr <= rd_data;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue holds expected {pc, instr} per transfer.
module tb_instr_fetch;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int base;

    logic [IW-1:0] model_mem [DEPTH];
    logic [AW+IW-1:0] sb [$];

    logic          prev_stall = 1'b0;
    logic [IW-1:0] prev_instr = '0;
    logic [AW-1:0] prev_pc = '0;

    instr_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_prog(input int len);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) sb.push_back({AW'(i), model_mem[i]});
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        load_we   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_we   = 1'b0;
        model_mem[addr] = data;
    endtask

    // Transfers are observed mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            xfers++;
            if (sb.size() == 0) begin
                chk("unexpected_xfer", {28'b0, pc}, 32'hFFFF_FFFF);
            end else begin
                logic [AW+IW-1:0] e;
                e = sb.pop_front();
                chk("xfer_pc", {28'b0, pc}, {28'b0, e[AW+IW-1:IW]});
                chk("xfer_instr", {20'b0, instr}, {20'b0, e[IW-1:0]});
            end
        end
        if (!rst && prev_stall && instr_valid) begin
            chk("stall_hold_instr", {20'b0, instr}, {20'b0, prev_instr});
            chk("stall_hold_pc", {28'b0, pc}, {28'b0, prev_pc});
        end
        prev_stall = !rst && instr_valid && !instr_ready;
        prev_instr = instr;
        prev_pc    = pc;
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pc", {28'b0, pc}, 32'd0);
        chk("rst_instr", {20'b0, instr}, 32'd0);
        rst = 1'b0;
        tick();

        load(0, 12'h000);
        load(1, 12'h001);
        load(2, 12'h010);
        for (int i = 3; i < DEPTH; i++) load(i, 12'(12'h100 + i * 3));

        // Basic run, ready tied high
        prog_len = 5'd3;
        base = xfers;
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_valid0", {31'b0, instr_valid}, 32'd1);
        chk("t1_busy0", {31'b0, busy}, 32'd1);
        chk("t1_pc0", {28'b0, pc}, 32'd0);
        chk("t1_instr0", {20'b0, instr}, 32'h000);
        tick();
        chk("t1_pc1", {28'b0, pc}, 32'd1);
        chk("t1_instr1", {20'b0, instr}, 32'h001);
        tick();
        chk("t1_pc2", {28'b0, pc}, 32'd2);
        chk("t1_instr2", {20'b0, instr}, 32'h010);
        tick();
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        chk("t1_valid_end", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'b0, done}, 32'd0);
        chk("t1_xfers", xfers - base, 32'd3);

        // Stall for 4 cycles at pc = 1
        base = xfers;
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_pc", {28'b0, pc}, 32'd1);
            chk("t2_stall_instr", {20'b0, instr}, 32'h001);
            chk("t2_stall_valid", {31'b0, instr_valid}, 32'd1);
            tick();
        end
        instr_ready = 1'b1;
        wait_done("t2_done");
        tick();
        chk("t2_xfers", xfers - base, 32'd3);

        // Zero length: done pulse only
        base = xfers;
        prog_len = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_valid", {31'b0, instr_valid}, 32'd0);
        chk("t3_done", {31'b0, done}, 32'd1);
        chk("t3_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("t3_done_pulse", {31'b0, done}, 32'd0);
        chk("t3_xfers", xfers - base, 32'd0);

        // Oversized length clamps to DEPTH
        base = xfers;
        prog_len = 5'd20;
        push_prog(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4_done");
        chk("t4_last_pc", {28'b0, pc}, 32'd15);
        tick();
        chk("t4_xfers", xfers - base, 32'd16);

        // Write coincident with start is dropped
        base = xfers;
        prog_len = 5'd3;
        push_prog(3);
        load_we = 1'b1;
        load_addr = '0;
        load_data = 12'h001;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_we = 1'b0;
        chk("t5_instr0", {20'b0, instr}, 32'h000);
        // Write during RUN is ignored
        instr_ready = 1'b0;
        load_we = 1'b1;
        load_addr = 4'd1;
        load_data = 12'hABC;
        tick();
        load_we = 1'b0;
        instr_ready = 1'b1;
        wait_done("t5_done");
        tick();
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5_rerun_done");
        tick();
        chk("t5_xfers", xfers - base, 32'd6);

        // Reset while the second instruction is presented
        base = xfers;
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_pc_before", {28'b0, pc}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("t6_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_pc", {28'b0, pc}, 32'd0);
        chk("t6_instr", {20'b0, instr}, 32'd0);
        chk("t6_xfers", xfers - base, 32'd1);
        base = xfers;
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_rerun_done");
        tick();
        chk("t6_rerun_xfers", xfers - base, 32'd3);

        // Back-to-back start on the done cycle
        base = xfers;
        push_prog(3);
        push_prog(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t7_done1");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_valid", {31'b0, instr_valid}, 32'd1);
        chk("t7_pc", {28'b0, pc}, 32'd0);
        chk("t7_instr", {20'b0, instr}, {20'b0, model_mem[0]});
        wait_done("t7_done2");
        tick();
        chk("t7_xfers", xfers - base, 32'd6);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
